// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared state encodings and default parameters for the fetch sequencer
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_IDLE   = 2'd2,
        ST_HALTED = 2'd3
    } pc_state_t;

    localparam int PC_W_DEF      = 8;
    localparam int RESET_VEC_DEF = 0;
    localparam int INC_DEF       = 1;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-PC select (increment, redirect, latched target or hold)
module pc_next #(
    parameter int          PC_W = 8,
    parameter int unsigned INC  = 1
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_issue,
    input  logic            i_ack,
    input  logic            i_redirect,
    input  logic [PC_W-1:0] i_redirect_target,
    input  logic            i_squash,
    input  logic [PC_W-1:0] i_latched_target,
    output logic [PC_W-1:0] o_pc_next,
    output logic            o_deliver,
    output logic            o_squash_ack
);

    localparam logic [PC_W-1:0] INC_W = PC_W'(INC);

    // While a request is outstanding the PC must stay put, so a redirect
    // only takes effect on the ack; elsewhere it loads immediately.
    always_comb begin
        o_pc_next    = i_pc;
        o_deliver    = 1'b0;
        o_squash_ack = 1'b0;
        if (i_issue) begin
            if (i_ack) begin
                if (i_redirect) begin
                    o_pc_next    = i_redirect_target;
                    o_squash_ack = 1'b1;
                end else if (i_squash) begin
                    o_pc_next    = i_latched_target;
                    o_squash_ack = 1'b1;
                end else begin
                    o_pc_next    = i_pc + INC_W;
                    o_deliver    = 1'b1;
                end
            end
        end else if (i_redirect) begin
            o_pc_next = i_redirect_target;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - PC fetch sequencer with imem handshake; PC_CTRL_PERF_EN adds fetch/squash counters
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
    parameter int unsigned     INC       = INC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            instr_valid,
    output logic [PC_W-1:0] instr_pc,
    input  logic            stall,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    output logic            halted,
    output logic [PC_W-1:0] pc
`ifdef PC_CTRL_PERF_EN
    ,
    output logic [15:0]     fetch_cnt,
    output logic [15:0]     squash_cnt
`endif
);

    pc_state_t       r_state;
    pc_state_t       w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_target;
    logic            r_squash;
    logic            r_instr_valid;
    logic [PC_W-1:0] r_instr_pc;
    logic [PC_W-1:0] w_pc_next;
    logic            w_deliver;
    logic            w_squash_ack;
    logic            w_issue;
    logic            w_resume;

    assign w_issue = (r_state == ST_ISSUE);
    // Target state when leaving IDLE/HALTED or finishing a fetch without halting.
    assign w_resume = stall ? 1'b1 : 1'b0;

    pc_next #(
        .PC_W (PC_W),
        .INC  (INC)
    ) u_pc_next (
        .i_pc              (r_pc),
        .i_issue           (w_issue),
        .i_ack             (imem_ack),
        .i_redirect        (redirect_valid),
        .i_redirect_target (redirect_target),
        .i_squash          (r_squash),
        .i_latched_target  (r_target),
        .o_pc_next         (w_pc_next),
        .o_deliver         (w_deliver),
        .o_squash_ack      (w_squash_ack)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Redirect outranks halt: it always lands in ISSUE, or IDLE under stall.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT, ST_IDLE: begin
                if (redirect_valid) begin
                    w_state_next = w_resume ? ST_IDLE : ST_ISSUE;
                end else if (halt) begin
                    w_state_next = ST_HALTED;
                end else begin
                    w_state_next = w_resume ? ST_IDLE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (imem_ack) begin
                    if (!redirect_valid && halt) begin
                        w_state_next = ST_HALTED;
                    end else begin
                        w_state_next = w_resume ? ST_IDLE : ST_ISSUE;
                    end
                end
            end
            ST_HALTED: begin
                if (redirect_valid) begin
                    w_state_next = w_resume ? ST_IDLE : ST_ISSUE;
                end
            end
            default: w_state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        imem_req = (r_state == ST_ISSUE);
        halted   = (r_state == ST_HALTED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_VEC;
            r_target      <= '0;
            r_squash      <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr_pc    <= '0;
        end else begin
            r_pc          <= w_pc_next;
            r_instr_valid <= w_deliver;
            if (w_deliver) begin
                r_instr_pc <= r_pc;
            end
            if (w_issue && imem_ack) begin
                r_squash <= 1'b0;
            end else if (w_issue && redirect_valid) begin
                r_squash <= 1'b1;
                r_target <= redirect_target;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr_pc    = r_instr_pc;

`ifdef PC_CTRL_PERF_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_squash_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt  <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (w_deliver && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (w_squash_ack && (r_squash_cnt != 16'hFFFF)) begin
                r_squash_cnt <= r_squash_cnt + 16'd1;
            end
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign squash_cnt = r_squash_cnt;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - self-checking bench for pc_ctrl: directed scenarios plus random traffic vs a fetch model
module tb_pc_ctrl;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'h10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         imem_ack = 1'b0;
    logic         stall = 1'b0;
    logic         halt = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [W-1:0] redirect_target = '0;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         instr_valid;
    logic [W-1:0] instr_pc;
    logic         halted;
    logic [W-1:0] pc;
`ifdef PC_CTRL_PERF_EN
    logic [15:0]  fetch_cnt;
    logic [15:0]  squash_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Model: a fetch is either outstanding, halted, or waiting; a redirect
    // against an outstanding fetch marks it stale until its ack returns.
    logic [7:0] m_pc, m_ipc, m_stale_tgt;
    bit         m_req, m_halted, m_iv, m_stale;
    int         m_nfetch, m_nsquash;

    pc_ctrl #(.PC_W(W), .RESET_VEC(RV), .INC(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .instr_valid     (instr_valid),
        .instr_pc        (instr_pc),
        .stall           (stall),
        .halt            (halt),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halted          (halted),
        .pc              (pc)
`ifdef PC_CTRL_PERF_EN
        ,
        .fetch_cnt       (fetch_cnt),
        .squash_cnt      (squash_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RV; m_ipc = '0; m_stale_tgt = '0;
        m_req = 0; m_halted = 0; m_iv = 0; m_stale = 0;
        m_nfetch = 0; m_nsquash = 0;
    endtask

    task automatic model_step(input bit s, input bit h, input bit r, input logic [7:0] t, input bit a);
        m_iv = 0;
        if (m_req) begin
            if (a) begin
                if (r) begin
                    m_pc = t; m_nsquash++;
                end else if (m_stale) begin
                    m_pc = m_stale_tgt; m_nsquash++;
                end else begin
                    m_iv = 1; m_ipc = m_pc; m_pc = m_pc + 8'd1; m_nfetch++;
                end
                m_stale = 0;
                if (!r && h) begin m_req = 0; m_halted = 1; end
                else m_req = !s;
            end else if (r) begin
                m_stale = 1; m_stale_tgt = t;
            end
        end else if (m_halted) begin
            if (r) begin m_pc = t; m_halted = 0; m_req = !s; end
        end else begin
            if (r) m_pc = t;
            if (!r && h) begin m_halted = 1; m_req = 0; end
            else m_req = !s;
        end
    endtask

    task automatic check_all();
        chk("imem_req", 32'(imem_req), 32'(m_req));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("instr_valid", 32'(instr_valid), 32'(m_iv));
        if (m_iv) chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
        if (m_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
`ifdef PC_CTRL_PERF_EN
        chk("fetch_cnt", 32'(fetch_cnt), 32'(m_nfetch));
        chk("squash_cnt", 32'(squash_cnt), 32'(m_nsquash));
`endif
    endtask

    // Called at a negedge: drive, clock once, check, return at the next negedge.
    task automatic cyc(input bit s, input bit h, input bit r, input logic [7:0] t, input bit a);
        bit ack;
        ack = a & m_req;
        stall = s; halt = h; redirect_valid = r; redirect_target = t; imem_ack = ack;
        model_step(s, h, r, t, ack);
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_instr_pc", 32'(instr_pc), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        cyc(0, 0, 0, 8'h00, 0);
        repeat (4) cyc(0, 0, 0, 8'h00, 1);
        cyc(1, 0, 0, 8'h00, 1);
        cyc(1, 0, 1, 8'h20, 0);
        cyc(0, 0, 0, 8'h00, 0);
        repeat (3) cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 1, 8'h30, 1);
        cyc(0, 0, 1, 8'h80, 0);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 1, 8'h80, 0);
        cyc(0, 0, 1, 8'h90, 0);
        cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 1, 8'h40, 1);
        cyc(0, 0, 1, 8'h05, 1);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 1, 8'h50, 1);
        cyc(1, 0, 0, 8'h00, 1);
        repeat (2) cyc(1, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 1, 0, 8'h00, 0);
        cyc(0, 1, 0, 8'h00, 1);
        repeat (3) cyc(0, 1, 0, 8'h00, 0);
        cyc(0, 0, 1, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 1, 8'hFF, 1);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 1);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 8) == 0, ($urandom % 16) == 0, ($urandom % 10) == 0,
                8'($urandom), ($urandom % 2) == 1);
        end

        cyc(0, 0, 1, 8'h33, 0);
        chk("pre_rst_req", 32'(imem_req), 32'h1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("async_rst_instr_pc", 32'(instr_pc), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
